// File: rtl/mem_driver_param.sv
// Request FSM in front of a DEPTH = 2**ADDR_W word register file, with a held read response.
// Optional PARITY_EN adds a stored even-parity bit per word, i_par_inject and o_parity_err.
module mem_driver_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_select,
  input  logic              i_operation,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ack,
`ifdef PARITY_EN
  input  logic              i_par_inject,
  output logic              o_parity_err,
`endif
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Handshake: a request transfers on a rising edge where i_select=1 and o_ready=1;
  // a response transfers on a rising edge where o_valid=1 and i_ack=1. i_select while
  // busy and i_ack while no response is held are ignored; o_data is stable while o_valid=1.
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
`ifdef PARITY_EN
  logic              inj_q;
  logic              err_q;
`endif

  always_comb begin
    rd_word = mem[addr_q];
`ifdef PARITY_EN
    wr_word = {(^data_q) ^ inj_q, data_q};
`else
    wr_word = data_q;
`endif
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
`ifdef PARITY_EN
      inj_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_select) begin
            addr_q <= i_addr;
            data_q <= i_data;
`ifdef PARITY_EN
            inj_q  <= i_par_inject;
`endif
            state  <= i_operation ? WRITE : READ;
          end
        end
        WRITE: begin
          mem[addr_q] <= wr_word;
          state       <= IDLE;
        end
        READ: begin
          rdata_q <= rd_word[DATA_W-1:0];
          valid_q <= 1'b1;
`ifdef PARITY_EN
          err_q   <= (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`endif
          state   <= RESP;
        end
        RESP: begin
          // o_data deliberately keeps the last response after the acknowledge
          if (i_ack) begin
            valid_q <= 1'b0;
`ifdef PARITY_EN
            err_q   <= 1'b0;
`endif
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_valid = valid_q;
  assign o_data  = rdata_q;
`ifdef PARITY_EN
  assign o_parity_err = err_q;
`endif

endmodule

// File: tb/tb_mem_driver_param.sv
// Directed bench for mem_driver_param: default 8x8 instance plus a 16-bit x 32-word instance.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_driver_param;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic       select = 1'b0, operation = 1'b0, ack = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] data = '0;
  logic       ready, valid, busy;
  logic [7:0] rdata;

  logic        select_w = 1'b0, operation_w = 1'b0, ack_w = 1'b0;
  logic [4:0]  addr_w = '0;
  logic [15:0] data_w = '0;
  logic        ready_w, valid_w, busy_w;
  logic [15:0] rdata_w;

`ifdef PARITY_EN
  logic par_inject = 1'b0, par_err;
  logic par_inject_w = 1'b0, par_err_w;
`endif

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  mem_driver_param dut (
    .i_clock(clk), .i_reset_n(reset_n), .i_select(select), .i_operation(operation),
    .i_addr(addr), .i_data(data), .i_ack(ack),
`ifdef PARITY_EN
    .i_par_inject(par_inject), .o_parity_err(par_err),
`endif
    .o_ready(ready), .o_valid(valid), .o_data(rdata), .o_busy(busy)
  );

  mem_driver_param #(.DATA_W(16), .ADDR_W(5)) dut_w (
    .i_clock(clk), .i_reset_n(reset_n), .i_select(select_w), .i_operation(operation_w),
    .i_addr(addr_w), .i_data(data_w), .i_ack(ack_w),
`ifdef PARITY_EN
    .i_par_inject(par_inject_w), .o_parity_err(par_err_w),
`endif
    .o_ready(ready_w), .o_valid(valid_w), .o_data(rdata_w), .o_busy(busy_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All driver tasks are entered on a falling edge and return on a falling edge.
  task automatic apply_reset();
    reset_n = 1'b0; select = 1'b0; ack = 1'b0; select_w = 1'b0; ack_w = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic inj);
    check("wr_ready", ready, 1);
    select = 1'b1; operation = 1'b1; addr = a; data = d;
`ifdef PARITY_EN
    par_inject = inj;
`endif
    @(negedge clk);
    select = 1'b0;
`ifdef PARITY_EN
    par_inject = 1'b0;
`endif
    check("wr_busy_ready", ready, 0);
    check("wr_busy", busy, 1);
    @(negedge clk);
    check("wr_done", ready, 1);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input int hold,
                    input bit poke, input logic exp_err);
    int  lat;
    bit  seen;
    logic [W-1:0] e;
    check("rd_ready", ready, 1);
    select = 1'b1; operation = 1'b0; addr = a;
    exp_q.push_back({8'h00, exp});
    lat = 0; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      select = 1'b0;
      lat++;
      if (valid) seen = 1;
    end
    check("rd_valid_seen", seen, 1);
    check("rd_latency", lat, 2);
    e = exp_q.pop_front();
    check("rd_data", {8'h00, rdata}, e);
`ifdef PARITY_EN
    check("rd_parity_err", par_err, exp_err);
`else
    if (exp_err) check("rd_no_parity", 0, 1);
`endif
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        select = (i % 2 == 0); operation = 1'b1; addr = a; data = 8'hFF;
      end
      @(negedge clk);
      check("hold_valid", valid, 1);
      check("hold_data", {8'h00, rdata}, e);
      check("hold_busy", busy, 1);
    end
    select = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_valid", valid, 0);
    check("ack_ready", ready, 1);
    check("ack_data_kept", {8'h00, rdata}, e);
  endtask

  task automatic wr_w(input logic [4:0] a, input logic [15:0] d);
    select_w = 1'b1; operation_w = 1'b1; addr_w = a; data_w = d;
    @(negedge clk);
    select_w = 1'b0;
    check("w_wr_busy", busy_w, 1);
    @(negedge clk);
    check("w_wr_done", ready_w, 1);
  endtask

  task automatic rd_w(input logic [4:0] a, input logic [15:0] exp);
    int lat;
    select_w = 1'b1; operation_w = 1'b0; addr_w = a;
    exp_q.push_back(exp);
    lat = 0;
    while (lat < 8 && !valid_w) begin
      @(negedge clk);
      select_w = 1'b0;
      lat++;
    end
    check("w_rd_latency", lat, 2);
    check("w_rd_data", rdata_w, exp_q.pop_front());
`ifdef PARITY_EN
    check("w_rd_parity_err", par_err_w, 0);
`endif
    ack_w = 1'b1;
    @(negedge clk);
    ack_w = 1'b0;
    check("w_ack_valid", valid_w, 0);
  endtask

  initial begin
    @(negedge clk);
    apply_reset();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_data", rdata, 0);

    // every word reads back zero after reset
    for (int a = 0; a < 8; a++) rd(a[2:0], 8'h00, 0, 0, 0);

    // write then immediate read of the same address
    wr(3'd5, 8'hA5, 0);
    rd(3'd5, 8'hA5, 0, 0, 0);

    wr(3'd0, 8'h01, 0);
    wr(3'd7, 8'h80, 0);
    wr(3'd3, 8'hFF, 0);
    rd(3'd0, 8'h01, 0, 0, 0);
    rd(3'd7, 8'h80, 0, 0, 0);
    rd(3'd3, 8'hFF, 0, 0, 0);
    rd(3'd5, 8'hA5, 0, 0, 0);
    wr(3'd5, 8'h3C, 0);
    rd(3'd5, 8'h3C, 0, 0, 0);

    // held response while write requests are pushed at the busy DUT
    wr(3'd2, 8'h5A, 0);
    rd(3'd2, 8'h5A, 10, 1, 0);
    rd(3'd2, 8'h5A, 0, 0, 0);

    // reset while in READ
    select = 1'b1; operation = 1'b0; addr = 3'd2;
    @(negedge clk);
    select = 1'b0;
    check("pre_rst_read_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_read_valid", valid, 0);
    check("rst_read_ready", ready, 1);
    check("rst_read_data", rdata, 0);

    // reset while a response is held
    wr(3'd1, 8'h99, 0);
    select = 1'b1; operation = 1'b0; addr = 3'd1;
    repeat (2) @(negedge clk);
    select = 1'b0;
    check("pre_rst_resp_valid", valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_resp_valid", valid, 0);
    check("rst_resp_ready", ready, 1);

    // reset while in WRITE: the pending write must not land
    select = 1'b1; operation = 1'b1; addr = 3'd4; data = 8'h77;
    @(negedge clk);
    select = 1'b0;
    check("pre_rst_write_ready", ready, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_write_ready", ready, 1);
    check("rst_write_valid", valid, 0);
    for (int a = 0; a < 8; a++) rd(a[2:0], 8'h00, 0, 0, 0);

    // wide instance: extreme addresses, no aliasing
    wr_w(5'd31, 16'hBEEF);
    wr_w(5'd0, 16'h1234);
    rd_w(5'd31, 16'hBEEF);
    rd_w(5'd0, 16'h1234);
    rd_w(5'd15, 16'h0000);
    rd_w(5'd16, 16'h0000);

`ifdef PARITY_EN
    wr(3'd6, 8'h3C, 1);
    rd(3'd6, 8'h3C, 2, 0, 1);
    wr(3'd6, 8'h3C, 0);
    rd(3'd6, 8'h3C, 0, 0, 0);
    wr(3'd6, 8'h07, 0);
    rd(3'd6, 8'h07, 0, 0, 0);
    wr(3'd6, 8'h07, 1);
    rd(3'd6, 8'h07, 0, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
